imem_loader: RTL and testbench

//  Writer side of the instruction memory. Accepts a byte stream (valid/ready) from a

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-memory constants and the loader state encoding.
// Revision: 1.0
`default_nettype none

package imem_pkg;

  localparam int IMEM_DEPTH_BYTES = 512;
  localparam int LEN_W            = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed byte stream into instruction memory, holding the core in reset until done.
// Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN. Revision: 1.0
`default_nettype none

module imem_loader #(
  parameter int DEPTH_BYTES = 512,
  parameter int ADDR_W      = 9,
  parameter int LEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import imem_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e FRAME_END = CHK;
`else
  localparam loader_state_e FRAME_END = DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              beat;
  logic [LEN_W-1:0]  hdr_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign beat    = rx_valid && rx_ready_q;
  assign hdr_len = {len_q[LEN_W-1:8], rx_data};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    if (beat && (state_q != CHK)) sum_d = sum_q + rx_data;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN_HI: begin
        if (beat) begin
          len_d   = {rx_data, {(LEN_W-8){1'b0}}};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (beat) begin
          len_d = hdr_len;
          if (hdr_len == '0)                          state_d = FRAME_END;
          else if (hdr_len > LEN_W'(DEPTH_BYTES))     state_d = ERR;
          else                                        state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = rx_data;
          cnt_d       = cnt_q + 1'b1;
          if (LEN_W'(cnt_q) == len_q - LEN_W'(1)) state_d = FRAME_END;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        // A correct trailing byte makes the running sum wrap to zero.
        if (beat) state_d = (8'(sum_q + rx_data) == 8'h00) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    rx_ready_d  = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                  (state_d == DATA)   || (state_d == CHK);
    busy_d      = rx_ready_d;
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    cpu_rst_n_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
`default_nettype none

module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready, mem_we, cpu_rst_n, busy, done, err;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  int         wq_addr[$];
  logic [7:0] wq_data[$];
  int         wq_cyc[$];
  int         cyc = 0;
  int         busy_gap = 0;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write log sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_we === 1'b1) begin
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic clr_w();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build(input int n, input int seed);
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    for (int i = 0; i < n; i++) tx_q.push_back(8'(i * 7 + seed));
  endtask

  // Sends tx_q from a negedge; optionally appends the checksum byte and raises start alongside byte start_idx.
  task automatic send_frame(input int gap, input bit add_chk, input int start_idx);
    logic [7:0] s;
    int n;
    s = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_chk) begin
      foreach (tx_q[i]) s = s + tx_q[i];
      tx_q.push_back(8'(0 - s));
    end
`endif
    n = tx_q.size();
    busy_gap = 0;
    for (int i = 0; i < n; i++) begin
      int t;
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      if (i == start_idx) start = 1'b1;
      t = 0;
      while (rx_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout byte %0d: rx_ready=%b, required 1", i, rx_ready);
        break;
      end
      @(negedge clk);
      start = 1'b0;
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) begin
          if (i < n - 1 && busy !== 1'b1) busy_gap++;
          @(negedge clk);
        end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clr_w();
    pulse_start();
    checks++;
    if ({busy, rx_ready, cpu_rst_n} !== 3'b110) begin
      errors++; $display("FAIL start_busy: busy/rdy/cpu_rst_n=%b, required 110", {busy, rx_ready, cpu_rst_n});
    end
    tx_q = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 4) begin
      errors++; $display("FAIL full_rate_count: got %0d writes, required 4", wq_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq_addr[i] !== i || wq_data[i] !== exp[i] || wq_cyc[i] !== wq_cyc[0] + i) begin
          errors++;
          $display("FAIL full_rate_write %0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   i, wq_addr[i], wq_data[i], wq_cyc[i], i, exp[i], wq_cyc[0] + i);
        end
      end
    end
    checks++;
    if ({done, cpu_rst_n, busy, err, mem_we} !== 5'b11000) begin
      errors++; $display("FAIL full_rate_done: done/cpu/busy/err/we=%b, required 11000",
                         {done, cpu_rst_n, busy, err, mem_we});
    end
    // Bytes offered while DONE must stay pending.
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || wq_addr.size() != 4 || done !== 1'b1) begin
      errors++; $display("FAIL done_no_accept: rx_ready=%b writes=%0d done=%b, required 0/4/1",
                         rx_ready, wq_addr.size(), done);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_toggle();
    clr_w();
    pulse_start();
    tx_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frame(1, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (busy_gap != 0) begin
      errors++; $display("FAIL toggle_busy: busy low %0d times, required 0", busy_gap);
    end
    checks++;
    if (wq_addr.size() != 3) begin
      errors++; $display("FAIL toggle_count: got %0d writes, required 3", wq_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq_addr[i] !== i || wq_data[i] !== tx_q[i + 2]) begin
          errors++; $display("FAIL toggle_write %0d: addr=%0d data=%h, required addr=%0d data=%h",
                             i, wq_addr[i], wq_data[i], i, tx_q[i + 2]);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL toggle_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_oversize();
    clr_w();
    pulse_start();
    tx_q = '{8'h02, 8'h01};
    send_frame(0, 1'b0, -1);
    checks++;
    if ({err, busy, cpu_rst_n, done, rx_ready} !== 5'b10000) begin
      errors++; $display("FAIL oversize_err: err/busy/cpu/done/rdy=%b, required 10000",
                         {err, busy, cpu_rst_n, done, rx_ready});
    end
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 0) begin
      errors++; $display("FAIL oversize_nowrite: got %0d writes, required 0", wq_addr.size());
    end
    pulse_start();
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++; $display("FAIL restart_clear_err: err/busy=%b, required 01", {err, busy});
    end
    tx_q = '{8'h00, 8'h01, 8'h5C};
    send_frame(0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || wq_addr.size() != 1) begin
      errors++; $display("FAIL after_err_load: done=%b err=%b writes=%0d, required 1/0/1",
                         done, err, wq_addr.size());
    end
  endtask

  task automatic test_full_image();
    int bad;
    clr_w();
    pulse_start();
    build(512, 3);
    send_frame(0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 512) begin
      errors++; $display("FAIL full_image_count: got %0d writes, required 512", wq_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 512; i++)
        if (wq_addr[i] !== i || wq_data[i] !== tx_q[i + 2]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL full_image_data: %0d bad writes, required 0", bad);
      end
      checks++;
      if (wq_addr[511] !== 511 || wq_cyc[511] !== wq_cyc[0] + 511) begin
        errors++; $display("FAIL full_image_last: addr=%0d span=%0d, required 511/511",
                           wq_addr[511], wq_cyc[511] - wq_cyc[0]);
      end
    end
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
      errors++; $display("FAIL full_image_done: done=%b cpu_rst_n=%b, required 1/1", done, cpu_rst_n);
    end
    clr_w();
    pulse_start();
    tx_q = '{8'h00, 8'h00};
    send_frame(0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wq_addr.size() != 0) begin
      errors++; $display("FAIL empty_image: done=%b busy=%b writes=%0d, required 1/0/0",
                         done, busy, wq_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    clr_w();
    pulse_start();
    tx_q = '{8'h00, 8'h06, 8'h01, 8'h02};
    send_frame(0, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b, required all zero",
               {rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_w();
    pulse_start();
    tx_q = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    send_frame(0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 3) begin
      errors++; $display("FAIL reload_count: got %0d writes, required 3", wq_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq_addr[i] !== i || wq_data[i] !== tx_q[i + 2]) begin
          errors++; $display("FAIL reload_write %0d: addr=%0d data=%h, required addr=%0d data=%h",
                             i, wq_addr[i], wq_data[i], i, tx_q[i + 2]);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL reload_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_start_busy();
    clr_w();
    pulse_start();
    tx_q = '{8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(0, 1'b1, 3);
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 4) begin
      errors++; $display("FAIL start_busy_count: got %0d writes, required 4", wq_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq_addr[i] !== i || wq_data[i] !== tx_q[i + 2]) begin
          errors++; $display("FAIL start_busy_write %0d: addr=%0d data=%h, required addr=%0d data=%h",
                             i, wq_addr[i], wq_data[i], i, tx_q[i + 2]);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL start_busy_done: done=%b busy=%b, required 1/0", done, busy);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    clr_w();
    pulse_start();
    // 00+01+5A = 5B; 8'hA5 is correct, 8'hA6 is not.
    tx_q = '{8'h00, 8'h01, 8'h5A, 8'hA6};
    send_frame(0, 1'b0, -1);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
      errors++; $display("FAIL bad_checksum: err=%b done=%b cpu=%b, required 1/0/0", err, done, cpu_rst_n);
    end
    pulse_start();
    tx_q = '{8'h00, 8'h01, 8'h5A, 8'hA5};
    send_frame(0, 1'b0, -1);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL good_checksum: done=%b err=%b, required 1/0", done, err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_toggle();
    test_oversize();
    test_full_image();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
